// File: rtl/uart_core.sv
// ----------------------------------------------------------------------------
// uart_core: 8N1 UART transceiver. The transmitter and receiver are fully
// independent and share one clock and one synchronous reset.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst        synchronous active-high reset
//   i_tx_enable  transmit request, accepted only while the transmitter is idle
//   i_tx_data    byte to transmit, latched together with the accepted request
//   o_tx         serial output, idles high
//   o_tx_busy    high for exactly 10 bit times per transmitted frame
//   i_rx         serial input, asynchronous to i_clk
//   o_rx_valid   one-cycle strobe when o_rx_byte has been updated
//   o_rx_byte    last correctly framed received byte
// ----------------------------------------------------------------------------
module uart_core #(
    parameter int ClkFreq  = 27_000_000,
    parameter int BaudRate = 115200
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tx_enable,
    input  logic [7:0] i_tx_data,
    output logic       o_tx,
    output logic       o_tx_busy,
    input  logic       i_rx,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_byte
);

    localparam int BaudCnt = ClkFreq / BaudRate;
    localparam int HalfCnt = BaudCnt / 2;
    localparam int CntW    = $clog2(BaudCnt) + 1;

    localparam logic [CntW-1:0] BaudLast = CntW'(BaudCnt - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(HalfCnt - 1);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    tx_state_e       tx_state_q, tx_state_d;
    logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_shift_q, tx_shift_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
        end
    end

    // Line level and busy are decoded from the registered state, so the
    // start bit and busy both appear on the edge after the request.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        o_tx       = 1'b1;
        o_tx_busy  = 1'b1;
        unique case (tx_state_q)
            TX_IDLE: begin
                o_tx_busy = 1'b0;
                tx_cnt_d  = '0;
                if (i_tx_enable) begin
                    tx_shift_d = i_tx_data;
                    tx_bit_d   = '0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                o_tx = 1'b0;
                if (tx_cnt_q == BaudLast) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                o_tx = tx_shift_q[0];
                if (tx_cnt_q == BaudLast) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                o_tx = 1'b1;
                if (tx_cnt_q == BaudLast) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_HOLD,   // good stop bit seen, waiting out its second half
        RX_ERR     // framing error, waiting for the line to return high
    } rx_state_e;

    logic            rx_meta_q, rx_sync_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic            rx_valid_q, rx_valid_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_meta_q  <= i_rx;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                // Re-check the line half a bit later to reject short glitches
                if (rx_cnt_q == HalfLast) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BaudLast) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BaudLast) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_sync_q ? RX_HOLD : RX_ERR;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_HOLD: begin
                // Publishing after the stop bit ends keeps valid behind tx_busy
                if (rx_cnt_q == HalfLast) begin
                    rx_cnt_d   = '0;
                    rx_byte_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_ERR: begin
                rx_cnt_d = '0;
                if (rx_sync_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign o_rx_valid = rx_valid_q;
    assign o_rx_byte  = rx_byte_q;

endmodule

// File: tb/tb_uart_core.sv
// ----------------------------------------------------------------------------
// tb_uart_core: directed self-checking bench for uart_core at default
// parameters (234 clocks per bit). The receiver is fed either from o_tx
// (loopback) or from a bench-driven line for malformed frames.
// ----------------------------------------------------------------------------
module tb_uart_core;

    localparam int Bit = 234;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_en = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx;
    logic       tx_busy;
    logic       rx_line;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       loop_en = 1'b1;
    logic       rx_manual = 1'b1;

    int tests = 0;
    int fails = 0;

    assign rx_line = loop_en ? tx : rx_manual;

    uart_core #(
        .ClkFreq (27_000_000),
        .BaudRate(115200)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_tx_enable(tx_en),
        .i_tx_data  (tx_data),
        .o_tx       (tx),
        .o_tx_busy  (tx_busy),
        .i_rx       (rx_line),
        .o_rx_valid (rx_valid),
        .o_rx_byte  (rx_byte)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for the receive strobe; leaves the bench in the strobe cycle.
    task automatic wait_valid(input int max_cycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (rx_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx_manual = frame[k];
            repeat (Bit) tick();
        end
        rx_manual = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (10) tick();
        tests++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx got=%b exp=1", tx); end
        tests++; if (tx_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
        tests++; if (rx_byte !== 8'h00) begin fails++; $display("FAIL reset_byte got=%h exp=00", rx_byte); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_tx_frame();
        logic [9:0] exp_bits;
        bit seen;
        exp_bits = 10'b1_10100101_0;
        tx_en = 1'b1; tx_data = 8'hA5;
        tick();
        tx_en = 1'b0; tx_data = 8'h00;
        tests++; if (tx_busy !== 1'b1) begin fails++; $display("FAIL tx_busy_rise got=%b exp=1", tx_busy); end
        for (int k = 0; k < 10; k++) begin
            tests++;
            if (tx !== exp_bits[k]) begin fails++; $display("FAIL tx_bit%0d_first got=%b exp=%b", k, tx, exp_bits[k]); end
            repeat (Bit - 1) tick();
            tests++;
            if (tx !== exp_bits[k]) begin fails++; $display("FAIL tx_bit%0d_last got=%b exp=%b", k, tx, exp_bits[k]); end
            if (k == 9) begin
                tests++; if (tx_busy !== 1'b1) begin fails++; $display("FAIL tx_busy_2339 got=%b exp=1", tx_busy); end
            end
            tick();
        end
        tests++; if (tx_busy !== 1'b0) begin fails++; $display("FAIL tx_busy_2340 got=%b exp=0", tx_busy); end
        wait_valid(50, seen);
        tests++; if (seen !== 1'b1) begin fails++; $display("FAIL tx_frame_rx_valid got=%b exp=1", seen); end
        tests++; if (rx_byte !== 8'hA5) begin fails++; $display("FAIL tx_frame_rx_byte got=%h exp=a5", rx_byte); end
        tick();
    endtask

    task automatic test_loopback();
        logic [7:0] b;
        bit seen;
        for (int n = 0; n < 15; n++) begin
            b = 8'($urandom_range(0, 255));
            tx_en = 1'b1; tx_data = b;
            tick();
            tx_en = 1'b0;
            tests++; if (tx_busy !== 1'b1) begin fails++; $display("FAIL echo%0d_busy got=%b exp=1", n, tx_busy); end
            tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL echo%0d_valid_early got=%b exp=0", n, rx_valid); end
            wait_valid(2600, seen);
            tests++; if (seen !== 1'b1) begin fails++; $display("FAIL echo%0d_timeout got=%b exp=1", n, seen); end
            tests++; if (tx_busy !== 1'b0) begin fails++; $display("FAIL echo%0d_busy_at_valid got=%b exp=0", n, tx_busy); end
            tests++; if (rx_byte !== b) begin fails++; $display("FAIL echo%0d_byte got=%h exp=%h", n, rx_byte, b); end
            tick();
        end
    endtask

    task automatic test_busy_ignore();
        bit seen;
        tx_en = 1'b1; tx_data = 8'h3C;
        tick();
        tx_en = 1'b0;
        repeat (1000) tick();
        tx_en = 1'b1; tx_data = 8'hFF;
        tick();
        tx_en = 1'b0;
        wait_valid(2600, seen);
        tests++; if (seen !== 1'b1) begin fails++; $display("FAIL busy_ign_valid got=%b exp=1", seen); end
        tests++; if (rx_byte !== 8'h3C) begin fails++; $display("FAIL busy_ign_byte got=%h exp=3c", rx_byte); end
        tick();
        wait_valid(3000, seen);
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL busy_ign_second_frame got=%b exp=0", seen); end
        tests++; if (tx_busy !== 1'b0) begin fails++; $display("FAIL busy_ign_idle got=%b exp=0", tx_busy); end
        tx_data = 8'h00;
    endtask

    task automatic test_glitch();
        bit seen;
        loop_en = 1'b0;
        rx_manual = 1'b0;
        repeat (50) tick();
        rx_manual = 1'b1;
        wait_valid(600, seen);
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL glitch_valid got=%b exp=0", seen); end
        send_frame(8'h5A, 1'b1);
        wait_valid(400, seen);
        tests++; if (seen !== 1'b1) begin fails++; $display("FAIL glitch_next_valid got=%b exp=1", seen); end
        tests++; if (rx_byte !== 8'h5A) begin fails++; $display("FAIL glitch_next_byte got=%h exp=5a", rx_byte); end
        tick();
    endtask

    task automatic test_framing();
        bit seen;
        send_frame(8'hC3, 1'b0);
        wait_valid(1000, seen);
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL frame_err_valid got=%b exp=0", seen); end
        tests++; if (rx_byte !== 8'h5A) begin fails++; $display("FAIL frame_err_byte_held got=%h exp=5a", rx_byte); end
        send_frame(8'h96, 1'b1);
        wait_valid(400, seen);
        tests++; if (seen !== 1'b1) begin fails++; $display("FAIL frame_err_next_valid got=%b exp=1", seen); end
        tests++; if (rx_byte !== 8'h96) begin fails++; $display("FAIL frame_err_next_byte got=%h exp=96", rx_byte); end
        tick();
        loop_en = 1'b1;
        repeat (5) tick();
    endtask

    task automatic test_reset_midframe();
        bit seen;
        tx_en = 1'b1; tx_data = 8'h81;
        tick();
        tx_en = 1'b0;
        repeat (500) tick();
        rst = 1'b1;
        tick();
        tests++; if (tx !== 1'b1) begin fails++; $display("FAIL midrst_tx got=%b exp=1", tx); end
        tests++; if (tx_busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got=%b exp=0", tx_busy); end
        tests++; if (rx_byte !== 8'h00) begin fails++; $display("FAIL midrst_byte got=%h exp=00", rx_byte); end
        rst = 1'b0;
        tick();
        wait_valid(3000, seen);
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL midrst_valid got=%b exp=0", seen); end
        tests++; if (tx_busy !== 1'b0) begin fails++; $display("FAIL midrst_busy_after got=%b exp=0", tx_busy); end
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_loopback();
        test_busy_ignore();
        test_glitch();
        test_framing();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
